// File: rtl/fifo_rd_line_sched.sv
// rtl/fifo_rd_line_sched.sv - read-side frame scheduler: pops 32-bit FIFO words, streams 16-bit pixels with SOF/EOL/EOF (optional stats: FIFO_RD_SCHED_STAT_EN)
module fifo_rd_line_sched #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int CNT_W    = 12
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        frame_start,
  output logic        fifo_rd_en,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        pix_vld,
  input  logic        pix_rdy,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort
`ifdef FIFO_RD_SCHED_STAT_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stall_cnt,
  output logic [15:0] abort_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORDS = H_ACTIVE * V_ACTIVE / 2;
  localparam int WL_W  = $clog2(WORDS + 1);
  localparam logic [WL_W-1:0]  WORDS_INIT = WL_W'(WORDS);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE - 1);

  logic [1:0]      state;
  logic [31:0]     hold;
  logic            hold_vld;
  logic            half;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [WL_W-1:0] words_left;
  logic            start_pend;
  logic            abort_q;

  logic run;
  logic xfer;
  logic pop;
  logic at_eol;
  logic at_eof;
  logic last_xfer;
  logic restart;
  logic enter;

  assign run       = (state == ST_RUN);
  assign xfer      = hold_vld && pix_rdy;
  assign at_eol    = (h_cnt == H_LAST);
  assign at_eof    = at_eol && (v_cnt == V_LAST);
  assign last_xfer = run && xfer && at_eof;
  // A start that lands on the final transfer behaves like a start in DONE.
  assign restart   = run && frame_start && !last_xfer;
  assign enter     = ((state == ST_IDLE) && frame_start) || restart ||
                     ((state == ST_DONE) && (frame_start || start_pend));

  // A restart cycle never pops, so the first word of the new frame is still at the FIFO head.
  assign fifo_rd_en = !rd_rst && run && !frame_start && (words_left != '0) &&
                      (!hold_vld || (half && pix_rdy));
  assign pop        = fifo_rd_en && fifo_rd_vld;

  assign pix_vld     = hold_vld;
  assign pix_data    = hold_vld ? (half ? hold[31:16] : hold[15:0]) : 16'h0000;
  assign pix_sof     = hold_vld && (h_cnt == '0) && (v_cnt == '0);
  assign pix_eol     = hold_vld && at_eol;
  assign pix_eof     = hold_vld && at_eof;
  assign busy        = run;
  assign frame_done  = (state == ST_DONE);
  assign frame_abort = abort_q;

  // Frame control: IDLE -> RUN -> DONE, with restart and deferred-start handling.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= ST_IDLE;
      start_pend <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      abort_q <= restart;
      case (state)
        ST_IDLE: if (frame_start) state <= ST_RUN;
        ST_RUN: begin
          if (last_xfer) begin
            state      <= ST_DONE;
            start_pend <= frame_start;
          end
        end
        ST_DONE: begin
          start_pend <= 1'b0;
          state      <= (frame_start || start_pend) ? ST_RUN : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register, pixel position counters and per-frame word budget.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      hold       <= '0;
      hold_vld   <= 1'b0;
      half       <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      words_left <= '0;
    end else if (enter) begin
      hold_vld   <= 1'b0;
      half       <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      words_left <= WORDS_INIT;
    end else if (run) begin
      if (pop) begin
        hold       <= fifo_rd_data;
        hold_vld   <= 1'b1;
        half       <= 1'b0;
        words_left <= words_left - WL_W'(1);
      end else if (xfer) begin
        if (!half) half <= 1'b1;
        else       hold_vld <= 1'b0;
      end
      if (xfer) begin
        if (at_eol) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef FIFO_RD_SCHED_STAT_EN
  logic stall_cond;
  assign stall_cond = run && !hold_vld && !fifo_rd_vld && (words_left != '0);

  // Saturating underflow-stall and abort counters; clear wins over increment.
  always_ff @(posedge rd_clk) begin
    if (rd_rst || stat_clr) begin
      stall_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (stall_cond && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (abort_q && (abort_cnt != '1))    abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule
